keypad_entry_ctrl: RTL and testbench

Parametrised successor to the keypad input encoder. Synchronises and debounces an N_KEYS one-hot keypad, then emits one load pulse per accepted key press. Accepted digits shift into an N_DIGITS BCD entry register. Also generates a single-cycle 1 Hz clock-enable tick, gated by the run/entry mode. Sits between the raw keypad pins and the time/display datapath; all outputs are in the clk domain.

---
 rtl/keypad_pkg.sv | 35 +++
 rtl/keypad_entry_ctrl_tick_gen.sv | 37 +++
 rtl/keypad_entry_ctrl.sv | 176 +++++++++++++++++
 tb/tb_keypad_entry_ctrl.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// keypad_pkg: shared types and helpers for the keypad entry controller.
//   kp_state_e  - debounce FSM states
//   calc_div    - clock cycles per tick period (CLK_HZ / TICK_HZ)
//   popcount16  - number of set bits in a (zero-extended) key vector
//   onehot_idx  - bit index of the highest set bit (the key's digit code)
package keypad_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } kp_state_e;

  function automatic int calc_div(input int clk_hz, input int tick_hz);
    return clk_hz / tick_hz;
  endfunction

  function automatic logic [4:0] popcount16(input logic [15:0] v);
    logic [4:0] c;
    c = '0;
    for (int i = 0; i < 16; i++) c = c + {4'b0, v[i]};
    return c;
  endfunction

  // Only meaningful for a one-hot input; multi-hot inputs never reach the
  // digit path because they are rejected before a load.
  function automatic logic [3:0] onehot_idx(input logic [15:0] v);
    logic [3:0] idx;
    idx = '0;
    for (int i = 0; i < 16; i++) if (v[i]) idx = 4'(i);
    return idx;
  endfunction

endpackage

// File: rtl/keypad_entry_ctrl_tick_gen.sv
// tick_gen: single-cycle clock-enable at TICK_HZ, run only in run mode.
//   clk      in  system clock
//   resetn   in  async active-low reset
//   enablen  in  1 = run (counter runs), 0 = entry (counter held at 0)
//   tick     out one-cycle pulse while tc == DIV-1
module tick_gen
  import keypad_pkg::*;
#(
  parameter int CLK_HZ  = 50000000,
  parameter int TICK_HZ = 1
) (
  input  logic clk,
  input  logic resetn,
  input  logic enablen,
  output logic tick
);

  localparam int DIV = calc_div(CLK_HZ, TICK_HZ);
  localparam int TW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [TW-1:0] TC_MAX = TW'(DIV - 1);

  logic [TW-1:0] tc_q, tc_d;

  always_comb begin
    tc_d = '0;
    if (enablen) tc_d = (tc_q == TC_MAX) ? '0 : tc_q + TW'(1);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) tc_q <= '0;
    else         tc_q <= tc_d;
  end

  // Gated with enablen so a drop in the terminal cycle never leaks a pulse.
  assign tick = enablen & (tc_q == TC_MAX);

endmodule

// File: rtl/keypad_entry_ctrl.sv
// keypad_entry_ctrl: synchronise + debounce a one-hot keypad, emit one load
// per accepted press and shift the digit into a BCD entry register.
//   clk, resetn   clock, async active-low reset
//   enablen       0 = entry mode (loads allowed), 1 = run mode (tick runs)
//   keypad        raw asynchronous key lines, active-high
//   clear_entry   synchronous clear of digits / entry_count
//   digit         code of last accepted key
//   load          one-cycle pulse per accepted press
//   digits        entry register, newest digit in [3:0]
//   entry_count   number of valid digits, saturating at N_DIGITS
//   key_held      debounced press active
//   multi_key     debounced press has more than one line high
//   tick          one-cycle enable at TICK_HZ
module keypad_entry_ctrl
  import keypad_pkg::*;
#(
  parameter int N_KEYS          = 10,
  parameter int N_DIGITS        = 4,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CLK_HZ          = 50000000,
  parameter int TICK_HZ         = 1
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          enablen,
  input  logic [N_KEYS-1:0]             keypad,
  input  logic                          clear_entry,
  output logic [3:0]                    digit,
  output logic                          load,
  output logic [4*N_DIGITS-1:0]         digits,
  output logic [$clog2(N_DIGITS+1)-1:0] entry_count,
  output logic                          key_held,
  output logic                          multi_key,
  output logic                          tick
);

  localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int CW = $clog2(N_DIGITS + 1);
  localparam logic [DW-1:0] DBC_MAX = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(N_DIGITS);

  logic [N_KEYS-1:0]     s1_q, s2_q, sync_key;
  logic [N_KEYS-1:0]     snap_q, snap_d;
  logic [DW-1:0]         dbc_q, dbc_d;
  kp_state_e             state_q, state_d;
  logic                  load_q, load_d;
  logic [3:0]            digit_q, digit_d;
  logic [4*N_DIGITS-1:0] digits_q, digits_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  held_q, held_d;
  logic                  multi_q, multi_d;
  logic                  accept;
  logic [4:0]            snap_pop;
  logic [3:0]            snap_idx;

  assign sync_key = s2_q;
  assign snap_pop = popcount16(16'(snap_q));
  assign snap_idx = onehot_idx(16'(snap_q));

  always_comb begin
    state_d  = state_q;
    snap_d   = snap_q;
    dbc_d    = dbc_q;
    held_d   = held_q;
    multi_d  = multi_q;
    load_d   = 1'b0;
    digit_d  = digit_q;
    digits_d = digits_q;
    cnt_d    = cnt_q;
    accept   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (sync_key != '0) begin
          snap_d  = sync_key;
          dbc_d   = '0;
          state_d = PRESS_WAIT;
        end
      end
      PRESS_WAIT: begin
        if (sync_key == '0) begin
          state_d = IDLE;
        end else if (sync_key != snap_q) begin
          snap_d = sync_key;
          dbc_d  = '0;
        end else if (dbc_q == DBC_MAX) begin
          // HELD entry: the only point where a press can become a load.
          state_d = HELD;
          held_d  = 1'b1;
          multi_d = (snap_pop > 5'd1);
          accept  = (snap_pop == 5'd1) && !enablen && !clear_entry;
        end else begin
          dbc_d = dbc_q + DW'(1);
        end
      end
      HELD: begin
        // Changes to another non-zero pattern are ignored: no auto-repeat.
        if (sync_key == '0) begin
          dbc_d   = '0;
          state_d = RELEASE_WAIT;
        end
      end
      RELEASE_WAIT: begin
        if (sync_key != '0) begin
          state_d = HELD;
        end else if (dbc_q == DBC_MAX) begin
          state_d = IDLE;
          held_d  = 1'b0;
          multi_d = 1'b0;
        end else begin
          dbc_d = dbc_q + DW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    if (accept) begin
      load_d   = 1'b1;
      digit_d  = snap_idx;
      // Truncating cast drops the oldest digit off the top.
      digits_d = (4*N_DIGITS)'({digits_q, snap_idx});
      cnt_d    = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);
    end

    if (clear_entry) begin
      digits_d = '0;
      cnt_d    = '0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      s1_q     <= '0;
      s2_q     <= '0;
      snap_q   <= '0;
      dbc_q    <= '0;
      state_q  <= IDLE;
      load_q   <= 1'b0;
      digit_q  <= '0;
      digits_q <= '0;
      cnt_q    <= '0;
      held_q   <= 1'b0;
      multi_q  <= 1'b0;
    end else begin
      s1_q     <= keypad;
      s2_q     <= s1_q;
      snap_q   <= snap_d;
      dbc_q    <= dbc_d;
      state_q  <= state_d;
      load_q   <= load_d;
      digit_q  <= digit_d;
      digits_q <= digits_d;
      cnt_q    <= cnt_d;
      held_q   <= held_d;
      multi_q  <= multi_d;
    end
  end

  assign digit       = digit_q;
  assign load        = load_q;
  assign digits      = digits_q;
  assign entry_count = cnt_q;
  assign key_held    = held_q;
  assign multi_key   = multi_q;

  tick_gen #(
    .CLK_HZ  (CLK_HZ),
    .TICK_HZ (TICK_HZ)
  ) u_tick (
    .clk     (clk),
    .resetn  (resetn),
    .enablen (enablen),
    .tick    (tick)
  );

endmodule

// File: tb/tb_keypad_entry_ctrl.sv
// Bench for keypad_entry_ctrl: expected loads are queued when a press is
// driven and popped by a monitor when load is seen. Inputs change 2 time
// units after posedge; outputs are sampled on negedge.
module tb_keypad_entry_ctrl;

  localparam int NK  = 10;
  localparam int ND  = 4;
  localparam int DEB = 4;
  localparam int LAT = DEB + 3;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          enablen = 1'b0;
  logic          clear_entry = 1'b0;
  logic [NK-1:0] keypad = '0;
  logic [3:0]    digit;
  logic          load;
  logic [15:0]   digits;
  logic [2:0]    entry_count;
  logic          key_held;
  logic          multi_key;
  logic          tick;

  typedef struct {
    int          cyc;
    logic [3:0]  dig;
    logic [15:0] digs;
    logic [2:0]  cnt;
  } exp_t;

  exp_t        sbq[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic [15:0] m_digits = '0;
  logic [2:0]  m_count = '0;

  keypad_entry_ctrl #(
    .N_KEYS(NK), .N_DIGITS(ND), .DEBOUNCE_CYCLES(DEB), .CLK_HZ(8), .TICK_HZ(1)
  ) dut (
    .clk(clk), .resetn(resetn), .enablen(enablen), .keypad(keypad),
    .clear_entry(clear_entry), .digit(digit), .load(load), .digits(digits),
    .entry_count(entry_count), .key_held(key_held), .multi_key(multi_key),
    .tick(tick)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // Called in the same slot the key is driven: first sync edge is cyc+1.
  task automatic expect_load(input int key);
    exp_t e;
    m_digits = {m_digits[11:0], 4'(key)};
    if (m_count != 3'(ND)) m_count = m_count + 3'd1;
    e.cyc  = cyc + LAT;
    e.dig  = 4'(key);
    e.digs = m_digits;
    e.cnt  = m_count;
    sbq.push_back(e);
  endtask

  task automatic press(input int key, input int hold, input int rel, input bit exp_ld);
    keypad = NK'(1) << key;
    if (exp_ld) expect_load(key);
    step(hold);
    keypad = '0;
    step(rel);
  endtask

  always @(negedge clk) begin
    if (load !== 1'b0) begin
      if (sbq.size() == 0) begin
        chk("spurious_load", 32'(load), 32'd0);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("load_cycle", 32'(cyc), 32'(e.cyc));
        chk("load_digit", 32'(digit), 32'(e.dig));
        chk("load_digits", 32'(digits), 32'(e.digs));
        chk("load_count", 32'(entry_count), 32'(e.cnt));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_digit", 32'(digit), 0);
    chk("rst_load", 32'(load), 0);
    chk("rst_digits", 32'(digits), 0);
    chk("rst_count", 32'(entry_count), 0);
    chk("rst_held", 32'(key_held), 0);
    chk("rst_multi", 32'(multi_key), 0);
    chk("rst_tick", 32'(tick), 0);
    step(1);
    resetn = 1'b1;
    step(2);

    // Single press of key 3
    keypad = NK'(1) << 3;
    expect_load(3);
    step(10);
    chk("held_during_press", 32'(key_held), 1);
    chk("digit_after_press", 32'(digit), 3);
    step(10);
    keypad = '0;
    step(12);
    chk("held_after_release", 32'(key_held), 0);
    chk("digits_one", 32'(digits), 32'h0003);

    // Keys 1..5: count saturates, oldest digits fall off
    for (int k = 1; k <= 5; k++) press(k, 10, 12, 1'b1);
    chk("digits_seq", 32'(digits), 32'h2345);
    chk("count_sat", 32'(entry_count), 4);

    // Bounce on key 5, then stable
    for (int i = 0; i < 6; i++) begin
      keypad = (i % 2 == 0) ? (NK'(1) << 5) : '0;
      step(2);
    end
    press(5, 12, 12, 1'b1);
    chk("digits_bounce", 32'(digits), 32'h3455);

    // Two keys at once: no load, multi_key until release debounced
    keypad = (NK'(1) << 2) | (NK'(1) << 7);
    step(10);
    chk("multi_set", 32'(multi_key), 1);
    chk("multi_held", 32'(key_held), 1);
    step(5);
    keypad = '0;
    step(3);
    chk("multi_in_release", 32'(multi_key), 1);
    step(9);
    chk("multi_clear", 32'(multi_key), 0);
    chk("multi_held_clear", 32'(key_held), 0);
    chk("digits_multi", 32'(digits), 32'h3455);

    // Run mode for 30 periods: ticks in periods 8, 16, 24; a press loads nothing
    enablen = 1'b1;
    for (int p = 1; p <= 30; p++) begin
      if (p == 3)  keypad = NK'(1) << 9;
      if (p == 15) keypad = '0;
      @(negedge clk);
      chk($sformatf("tickA_p%0d", p), 32'(tick), 32'(p % 8 == 0));
      @(posedge clk);
      #2;
    end
    enablen = 1'b0;
    step(12);
    chk("digits_runmode", 32'(digits), 32'h3455);
    chk("tick_off", 32'(tick), 0);

    // Run mode dropped at period 20: no tick at 24
    step(3);
    enablen = 1'b1;
    for (int p = 1; p <= 30; p++) begin
      if (p == 20) enablen = 1'b0;
      @(negedge clk);
      chk($sformatf("tickB_p%0d", p), 32'(tick), 32'(p < 20 && p % 8 == 0));
      @(posedge clk);
      #2;
    end

    // Reset during PRESS_WAIT, key held through reset release
    keypad = NK'(1) << 6;
    step(4);
    resetn = 1'b0;
    #1;
    chk("amid_rst_digits", 32'(digits), 0);
    chk("amid_rst_count", 32'(entry_count), 0);
    chk("amid_rst_digit", 32'(digit), 0);
    chk("amid_rst_held", 32'(key_held), 0);
    chk("amid_rst_load", 32'(load), 0);
    chk("amid_rst_multi", 32'(multi_key), 0);
    step(2);
    resetn = 1'b1;
    m_digits = '0;
    m_count = '0;
    expect_load(6);
    step(15);
    keypad = '0;
    step(12);
    chk("digits_after_rst", 32'(digits), 32'h0006);

    // clear_entry coincident with HELD entry: clear wins, no load
    keypad = NK'(1) << 8;
    step(LAT - 1);
    clear_entry = 1'b1;
    step(1);
    clear_entry = 1'b0;
    m_digits = '0;
    m_count = '0;
    chk("clr_digits", 32'(digits), 0);
    chk("clr_count", 32'(entry_count), 0);
    chk("clr_held", 32'(key_held), 1);
    step(10);
    keypad = '0;
    step(12);

    press(7, 10, 12, 1'b1);
    chk("digits_after_clr", 32'(digits), 32'h0007);
    chk("count_after_clr", 32'(entry_count), 1);

    chk("pending_loads", 32'(sbq.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
